// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings,
// FSM states, default geometry and small decode helpers.
package md_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_MUL_LAT = 4;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MSUB  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        FIX  = 2'b11
    } state_e;

    // True for the six defined operations; all other codes are no-ops.
    function automatic logic op_is_valid(input logic [2:0] op);
        logic ok;
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MSUB: ok = 1'b1;
            default:                                              ok = 1'b0;
        endcase
        return ok;
    endfunction

    // True for the two divide operations.
    function automatic logic op_is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/md_div_core.sv
// Iterative restoring divider on unsigned magnitudes. The first iteration
// runs on the start edge, so after WIDTH edges (start edge included) the
// quotient/remainder are final and done is high for one cycle.
module md_div_core
    import md_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dsr_r;
    logic [CW-1:0]    cnt_r;
    logic             done_r;

    // One restoring step: shift the next dividend bit into the partial
    // remainder, subtract the divisor if it fits, shift the quotient bit in.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                    input logic [WIDTH-1:0] quo,
                                                    input logic [WIDTH-1:0] dsr);
        logic [WIDTH:0] tmp;
        logic [WIDTH:0] diff;
        logic [2*WIDTH-1:0] res;
        tmp  = {rem, quo[WIDTH-1]};
        diff = tmp - {1'b0, dsr};
        if (diff[WIDTH] == 1'b0) begin
            res = {diff[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
        end else begin
            res = {tmp[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
        end
        return res;
    endfunction

    // Iteration register: load and first step on start, then count down.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_r  <= {WIDTH{1'b0}};
            quo_r  <= {WIDTH{1'b0}};
            dsr_r  <= {WIDTH{1'b0}};
            cnt_r  <= CNT_ZERO;
            done_r <= 1'b0;
        end else if (abort) begin
            cnt_r  <= CNT_ZERO;
            done_r <= 1'b0;
        end else if (start) begin
            {rem_r, quo_r} <= div_step({WIDTH{1'b0}}, dividend, divisor);
            dsr_r          <= divisor;
            cnt_r          <= CNT_LOAD;
            done_r         <= 1'b0;
        end else if (cnt_r != CNT_ZERO) begin
            {rem_r, quo_r} <= div_step(rem_r, quo_r, dsr_r);
            cnt_r          <= cnt_r - CNT_ONE;
            done_r         <= (cnt_r == CNT_ONE);
        end else begin
            done_r <= 1'b0;
        end
    end

    assign done      = done_r;
    assign quotient  = quo_r;
    assign remainder = rem_r;

endmodule

// File: rtl/md_seq.sv
// HI/LO multiply/divide sequencer: pipelined-latency multiplier with
// accumulate, iterative divider with a final sign-fix cycle, direct HI/LO
// writes, cancel and synchronous reset.
module md_seq
    import md_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MUL_LAT = DEF_MUL_LAT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hl_write,
    input  logic             hl_sel,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div0
);

    state_e               state_r;
    state_e               state_nxt_s;
    logic [2:0]           op_r;
    logic [2*WIDTH-1:0]   prod_r;
    logic [MUL_LAT-1:0]   vld_r;
    logic                 q_neg_r;
    logic                 r_neg_r;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;
    logic                 busy_r;
    logic                 done_r;

    logic                 div0_s;
    logic                 accept_s;
    logic                 wr_s;
    logic                 is_div_s;
    logic                 sdiv_s;
    logic [2*WIDTH-1:0]   ax_s;
    logic [2*WIDTH-1:0]   bx_s;
    logic [2*WIDTH-1:0]   prod_s;
    logic [WIDTH-1:0]     a_mag_s;
    logic [WIDTH-1:0]     b_mag_s;
    logic [2*WIDTH-1:0]   res_s;
    logic                 div_done_s;
    logic [WIDTH-1:0]     quo_s;
    logic [WIDTH-1:0]     rem_s;

    assign is_div_s = op_is_div(op);
    assign sdiv_s   = (op == OP_DIV);
    assign div0_s   = start & is_div_s & (b == {WIDTH{1'b0}});

    // Next-state decode and per-cycle accept / result-write strobes.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        wr_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && !cancel && op_is_valid(op) && !div0_s) begin
                    accept_s    = 1'b1;
                    state_nxt_s = is_div_s ? DIV : MUL;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            MUL: begin
                if (cancel) begin
                    state_nxt_s = IDLE;
                end else if (vld_r[MUL_LAT-1]) begin
                    wr_s        = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = MUL;
                end
            end
            DIV: begin
                if (cancel) begin
                    state_nxt_s = IDLE;
                end else if (div_done_s) begin
                    state_nxt_s = FIX;
                end else begin
                    state_nxt_s = DIV;
                end
            end
            FIX: begin
                if (cancel) begin
                    state_nxt_s = IDLE;
                end else begin
                    wr_s        = 1'b1;
                    state_nxt_s = IDLE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Operand conditioning: sign/zero extension for the product and
    // absolute values for the divider.
    always_comb begin
        if (op == OP_MULTU) begin
            ax_s = {{WIDTH{1'b0}}, a};
            bx_s = {{WIDTH{1'b0}}, b};
        end else begin
            ax_s = {{WIDTH{a[WIDTH-1]}}, a};
            bx_s = {{WIDTH{b[WIDTH-1]}}, b};
        end
        prod_s  = ax_s * bx_s;
        a_mag_s = (sdiv_s && a[WIDTH-1]) ? (-a) : a;
        b_mag_s = (sdiv_s && b[WIDTH-1]) ? (-b) : b;
    end

    // Result selection for the completion edge; MADD/MSUB read HI/LO now.
    always_comb begin
        case (op_r)
            OP_MULT, OP_MULTU: res_s = prod_r;
            OP_MADD:           res_s = {hi_r, lo_r} + prod_r;
            OP_MSUB:           res_s = {hi_r, lo_r} - prod_r;
            OP_DIV, OP_DIVU:   res_s = {(r_neg_r ? (-rem_s) : rem_s),
                                        (q_neg_r ? (-quo_s) : quo_s)};
            default:           res_s = {hi_r, lo_r};
        endcase
    end

    md_div_core #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (accept_s & is_div_s),
        .abort     (cancel),
        .dividend  (a_mag_s),
        .divisor   (b_mag_s),
        .done      (div_done_s),
        .quotient  (quo_s),
        .remainder (rem_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operation latch, product register and multiply latency shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r    <= OP_MULT;
            prod_r  <= {(2*WIDTH){1'b0}};
            q_neg_r <= 1'b0;
            r_neg_r <= 1'b0;
            vld_r   <= {MUL_LAT{1'b0}};
        end else begin
            if (accept_s) begin
                op_r    <= op;
                prod_r  <= prod_s;
                q_neg_r <= sdiv_s & (a[WIDTH-1] ^ b[WIDTH-1]);
                r_neg_r <= sdiv_s & a[WIDTH-1];
            end else begin
                op_r <= op_r;
            end
            if (cancel) begin
                vld_r <= {MUL_LAT{1'b0}};
            end else begin
                vld_r[0] <= accept_s & ~is_div_s;
                for (int i = 1; i < MUL_LAT; i++) begin
                    vld_r[i] <= vld_r[i-1];
                end
            end
        end
    end

    // HI/LO registers plus registered busy/done status.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_r   <= {WIDTH{1'b0}};
            lo_r   <= {WIDTH{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            if (wr_s) begin
                {hi_r, lo_r} <= res_s;
            end else if (hl_write && (state_r == IDLE)) begin
                if (hl_sel) begin
                    lo_r <= a;
                end else begin
                    hi_r <= a;
                end
            end else begin
                hi_r <= hi_r;
            end
            busy_r <= (state_nxt_s != IDLE);
            done_r <= wr_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;
    assign div0 = div0_s;

endmodule
